// File: rtl/bsg_fsb_node_ls_iso_buffer.sv
// Purpose: node-domain isolation buffer between the FSB level shifters and the node core.
// Latency: 1 cycle minimum from enqueue to head; data outputs are registered FIFO heads.
// Backpressure: ready reflects link state and FIFO fullness only; all handshakes are blocked unless the link is ON.
//
// Ports:
//   clk_i, reset_n_i          node clock, synchronous active-low reset
//   en_ls_i                   level-shifter enable (1 = link powered)
//   ls_v_i/ls_data_i/ls_ready_o      FSB->node input from shifter
//   core_v_o/core_data_o/core_yumi_i FSB->node output to core
//   core_v_i/core_data_i/core_ready_o node->FSB input from core
//   ls_v_o/ls_data_o/ls_yumi_i       node->FSB output to shifter
//   link_on_o                 high while the link is ON
//   flush_o                   one-cycle pulse after a non-empty FIFO is flushed

// Purpose: small circular FIFO with registered head and synchronous clear.
// Latency: an entry written at edge N is on data_o from cycle N+1.
// Backpressure: caller must gate enq_i with !full_o and deq_i with !empty_o.
module bsg_fsb_node_ls_iso_fifo #(
  parameter int width_p = 5,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [width_p-1:0] data_o
);

  localparam int lg_els_lp = $clog2(els_p);

  logic [width_p-1:0]   mem_r [els_p];
  logic [lg_els_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [lg_els_lp:0]   count_r;

  assign full_o  = (count_r == (lg_els_lp+1)'(els_p));
  assign empty_o = (count_r == '0);
  assign data_o  = mem_r[rd_ptr_r];

  // Clear wins over any same-cycle enqueue/dequeue so nothing stale survives isolation.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clear_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq_i) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (deq_i) rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({enq_i, deq_i})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset: occupancy decides what is visible.
  always_ff @(posedge clk_i) begin
    if (enq_i && !clear_i) mem_r[wr_ptr_r] <= data_i;
  end

endmodule

module bsg_fsb_node_ls_iso_buffer #(
  parameter int width_p         = 5,
  parameter int els_p           = 2,
  parameter int settle_cycles_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_ls_i,
  input  logic               ls_v_i,
  input  logic [width_p-1:0] ls_data_i,
  output logic               ls_ready_o,
  output logic               ls_v_o,
  output logic [width_p-1:0] ls_data_o,
  input  logic               ls_yumi_i,
  output logic               core_v_o,
  output logic [width_p-1:0] core_data_o,
  input  logic               core_yumi_i,
  input  logic               core_v_i,
  input  logic [width_p-1:0] core_data_i,
  output logic               core_ready_o,
  output logic               link_on_o,
  output logic               flush_o
);

  localparam int cnt_w_lp = $clog2(settle_cycles_p + 1);

  typedef enum logic [1:0] {OFF, SETTLE, ON} state_e;

  state_e              state_r, state_n;
  logic [cnt_w_lp-1:0] cnt_r, cnt_n;
  logic                flush_r;

  logic                on;
  logic                clear;
  logic                in_full, in_empty, out_full, out_empty;
  logic [width_p-1:0]  in_head, out_head;
  logic                in_enq, in_deq, out_enq, out_deq;

  // ---------------- power sequencing FSM ----------------
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= OFF;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    if (!en_ls_i) begin
      state_n = OFF;
      cnt_n   = '0;
    end else begin
      case (state_r)
        OFF: begin
          state_n = SETTLE;
          cnt_n   = '0;
        end
        SETTLE: begin
          // Exit on the last settle count so ON lands exactly settle_cycles_p edges after enable.
          if (cnt_r == cnt_w_lp'(settle_cycles_p - 1)) state_n = ON;
          cnt_n = cnt_r + 1'b1;
        end
        ON:      state_n = ON;
        default: state_n = OFF;
      endcase
    end
  end

  assign on        = (state_r == ON);
  assign link_on_o = on;
  assign clear     = !en_ls_i;

  // Flush pulse is registered so it lines up with the first isolated cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) flush_r <= 1'b0;
    else            flush_r <= clear && (!in_empty || !out_empty);
  end
  assign flush_o = flush_r;

  // ---------------- FSB -> node ----------------
  assign ls_ready_o  = on && !in_full;
  assign core_v_o    = on && !in_empty;
  assign core_data_o = core_v_o ? in_head : '0;
  assign in_enq      = ls_v_i && ls_ready_o;
  assign in_deq      = core_yumi_i && core_v_o;

  bsg_fsb_node_ls_iso_fifo #(.width_p(width_p), .els_p(els_p)) in_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (clear),
    .enq_i     (in_enq),
    .data_i    (ls_data_i),
    .deq_i     (in_deq),
    .full_o    (in_full),
    .empty_o   (in_empty),
    .data_o    (in_head)
  );

  // ---------------- node -> FSB ----------------
  assign core_ready_o = on && !out_full;
  assign ls_v_o       = on && !out_empty;
  assign ls_data_o    = ls_v_o ? out_head : '0;
  assign out_enq      = core_v_i && core_ready_o;
  assign out_deq      = ls_yumi_i && ls_v_o;

  bsg_fsb_node_ls_iso_fifo #(.width_p(width_p), .els_p(els_p)) out_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (clear),
    .enq_i     (out_enq),
    .data_i    (core_data_i),
    .deq_i     (out_deq),
    .full_o    (out_full),
    .empty_o   (out_empty),
    .data_o    (out_head)
  );

endmodule

// File: tb/tb_bsg_fsb_node_ls_iso_buffer.sv
// Purpose: directed self-checking bench for bsg_fsb_node_ls_iso_buffer.
// Latency: expectations are hand-derived cycle by cycle.
// Backpressure: yumi is only driven while the matching valid is high.
module tb_bsg_fsb_node_ls_iso_buffer;

  logic       clk_i = 1'b0;
  logic       reset_n_i, en_ls_i;
  logic       ls_v_i, ls_ready_o, ls_v_o, ls_yumi_i;
  logic [4:0] ls_data_i, ls_data_o;
  logic       core_v_o, core_yumi_i, core_v_i, core_ready_o;
  logic [4:0] core_data_o, core_data_i;
  logic       link_on_o, flush_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  bsg_fsb_node_ls_iso_buffer #(.width_p(5), .els_p(2), .settle_cycles_p(4)) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .en_ls_i      (en_ls_i),
    .ls_v_i       (ls_v_i),
    .ls_data_i    (ls_data_i),
    .ls_ready_o   (ls_ready_o),
    .ls_v_o       (ls_v_o),
    .ls_data_o    (ls_data_o),
    .ls_yumi_i    (ls_yumi_i),
    .core_v_o     (core_v_o),
    .core_data_o  (core_data_o),
    .core_yumi_i  (core_yumi_i),
    .core_v_i     (core_v_i),
    .core_data_i  (core_data_i),
    .core_ready_o (core_ready_o),
    .link_on_o    (link_on_o),
    .flush_o      (flush_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_hs_off(input string tag);
    chk({tag, "_ls_ready"},   ls_ready_o,   0);
    chk({tag, "_ls_v"},       ls_v_o,       0);
    chk({tag, "_core_v"},     core_v_o,     0);
    chk({tag, "_core_ready"}, core_ready_o, 0);
    chk({tag, "_link_on"},    link_on_o,    0);
  endtask

  // Yumi must never be offered without a matching valid.
  always @(negedge clk_i) begin
    if (reset_n_i === 1'b1) begin
      if (core_yumi_i) chk("core_yumi_legal", core_v_o, 1);
      if (ls_yumi_i)   chk("ls_yumi_legal",   ls_v_o,   1);
    end
  end

  initial begin
    int sent, got, cyc;
    reset_n_i = 0; en_ls_i = 1;
    ls_v_i = 0; ls_data_i = 0; ls_yumi_i = 0;
    core_v_i = 0; core_data_i = 0; core_yumi_i = 0;

    // ---- reset then settle ----
    repeat (3) tick();
    chk_hs_off("rst");
    chk("rst_flush", flush_o, 0);
    chk("rst_ls_data", ls_data_o, 0);
    chk("rst_core_data", core_data_o, 0);
    reset_n_i = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_hs_off("settle");
    end
    tick();
    chk("on_link", link_on_o, 1);
    chk("on_ls_ready", ls_ready_o, 1);
    chk("on_core_ready", core_ready_o, 1);

    // ---- FSB->node ordering ----
    ls_v_i = 1; ls_data_i = 5'h01;
    tick();
    chk("ord_v1", core_v_o, 1);
    chk("ord_d1", core_data_o, 5'h01);
    chk("ord_rdy1", ls_ready_o, 1);
    ls_data_i = 5'h02;
    tick();
    chk("ord_full_rdy", ls_ready_o, 0);
    chk("ord_head_hold", core_data_o, 5'h01);
    ls_data_i = 5'h03;
    tick();
    chk("ord_refused_rdy", ls_ready_o, 0);
    core_yumi_i = 1;
    tick();
    chk("ord_d2", core_data_o, 5'h02);
    chk("ord_rdy_again", ls_ready_o, 1);
    tick();
    chk("ord_d3", core_data_o, 5'h03);
    ls_v_i = 0;
    tick();
    chk("ord_empty_v", core_v_o, 0);
    chk("ord_empty_d", core_data_o, 0);
    core_yumi_i = 0;

    // ---- node->FSB with backpressure ----
    core_v_i = 1; core_data_i = 5'h1F;
    tick();
    chk("bp_v", ls_v_o, 1);
    chk("bp_d", ls_data_o, 5'h1F);
    core_data_i = 5'h0A;
    tick();
    chk("bp_full_rdy", core_ready_o, 0);
    core_v_i = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_v", ls_v_o, 1);
      chk("bp_hold_d", ls_data_o, 5'h1F);
      chk("bp_hold_rdy", core_ready_o, 0);
    end
    ls_yumi_i = 1;
    tick();
    chk("bp_d2", ls_data_o, 5'h0A);
    chk("bp_rdy", core_ready_o, 1);
    tick();
    chk("bp_drained", ls_v_o, 0);
    ls_yumi_i = 0;

    // ---- isolation mid-traffic ----
    ls_v_i = 1; ls_data_i = 5'h07; core_v_i = 1; core_data_i = 5'h09;
    tick();
    ls_v_i = 0; core_v_i = 0;
    chk("iso_pre_core_v", core_v_o, 1);
    chk("iso_pre_ls_v", ls_v_o, 1);
    en_ls_i = 0;
    tick();
    chk_hs_off("iso");
    chk("iso_flush", flush_o, 1);
    en_ls_i = 1;
    tick();
    chk("iso_flush_once", flush_o, 0);
    chk_hs_off("iso_settle0");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_hs_off("iso_settle");
    end
    tick();
    chk("iso_on", link_on_o, 1);
    chk("iso_core_v_empty", core_v_o, 0);
    chk("iso_ls_v_empty", ls_v_o, 0);

    // ---- settle glitch ----
    en_ls_i = 0;
    tick();
    chk("gl_noflush", flush_o, 0);
    en_ls_i = 1;
    tick();
    tick();
    chk_hs_off("gl_first");
    en_ls_i = 0;
    tick();
    chk_hs_off("gl_drop");
    en_ls_i = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_hs_off("gl_settle");
    end
    tick();
    chk("gl_on", link_on_o, 1);
    chk("gl_ready", ls_ready_o, 1);

    // ---- full-rate streaming ----
    sent = 0; got = 0; cyc = 0;
    while (got < 20 && cyc < 100) begin
      ls_v_i    = (sent < 20);
      ls_data_i = 5'(sent + 1);
      core_yumi_i = core_v_o;
      if (core_v_o) begin
        chk("stream_data", core_data_o, 32'(got + 1));
        got++;
      end
      if (ls_v_i && ls_ready_o) sent++;
      tick();
      cyc++;
    end
    ls_v_i = 0; core_yumi_i = 0;
    chk("stream_count", got, 20);
    chk("stream_cycles", cyc, 21);
    chk("stream_empty", core_v_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bsg_fsb_node_ls_iso_buffer.md
Name: bsg_fsb_node_ls_iso_buffer

Overview:
- Node-domain stage between the node-domain FSB level-shift block and the node core.
- Buffers traffic in both directions with small FIFOs.
- Sequences power-isolation enable: traffic stays blocked until the shifters have settled after en_ls_i rises.
- Flushes buffered state immediately when isolation re-engages (en_ls_i falls), so no stale data crosses after re-enable.

Parameters:
- width_p, 5, data width in both directions.
- els_p, 2, FIFO depth per direction (power of two, >=2).
- settle_cycles_p, 4, cycles after en_ls_i rises before traffic is allowed (>=1).

Ports:
- clk_i  in  1  node-domain clock
- reset_n_i  in  1  reset, synchronous and active-low
- en_ls_i  in  1  level-shifter enable (1 = link powered/unisolated)
- ls_v_i  in  1  FSB->node valid, from shifter
- ls_data_i  in  width_p  FSB->node data
- ls_ready_o  out  1  ready to accept FSB->node data
- ls_v_o  out  1  node->FSB valid, to shifter
- ls_data_o  out  width_p  node->FSB data
- ls_yumi_i  in  1  FSB consumed ls_data_o
- core_v_o  out  1  FSB->node valid, to core
- core_data_o  out  width_p  FSB->node data to core
- core_yumi_i  in  1  core consumed core_data_o
- core_v_i  in  1  node->FSB valid, from core
- core_data_i  in  width_p  node->FSB data from core
- core_ready_o  out  1  ready to accept core data
- link_on_o  out  1  high when FSM is in ON
- flush_o  out  1  one-cycle pulse when a non-empty FIFO is flushed

Behaviour:
- Clock and reset: single clock clk_i. reset_n_i=0 at a rising edge puts the FSM in OFF, empties both FIFOs and zeroes the settle counter.
- Reset values: all outputs 0 (ls_ready_o, ls_v_o, core_v_o, core_ready_o, link_on_o, flush_o). Data outputs are 0 while their valid is 0.
- FSM state OFF:
  - en_ls_i=1 -> SETTLE with counter=0.
- FSM state SETTLE:
  - Counter increments each cycle.
  - When counter==settle_cycles_p-1 and en_ls_i=1 -> ON. ON is therefore entered exactly settle_cycles_p cycles after the first en_ls_i=1 edge is sampled.
- FSM state ON:
  - Normal traffic; link_on_o=1.
- Any state, en_ls_i=0 -> OFF on the next edge.
  - Both FIFOs are emptied on that same edge.
  - flush_o pulses for one cycle if either FIFO held ≥1 entry.
  - An en_ls_i glitch during SETTLE restarts settling from OFF.
- Gating: all four handshake outputs (ls_ready_o, ls_v_o, core_v_o, core_ready_o) are forced 0 unless state==ON, independent of FIFO contents.
- FSB->node FIFO:
  - Enqueue when ls_v_i & ls_ready_o.
  - ls_ready_o = ON & !full.
  - core_v_o = ON & !empty.
  - Dequeue on core_yumi_i. Yumi is only legal when core_v_o=1; the bench asserts it is never high otherwise.
- Node->FSB FIFO:
  - Enqueue when core_v_i & core_ready_o.
  - core_ready_o = ON & !full.
  - ls_v_o = ON & !empty.
  - Dequeue on ls_yumi_i.
- FIFO behaviour (both directions):
  - Data output is the head entry and is registered (no fall-through).
  - An entry enqueued at edge N is visible on the output from cycle N+1, giving 1-cycle minimum latency.
  - ready depends only on state and full, never on yumi (no combinational ready-from-yumi path).
  - Simultaneous enqueue and dequeue when full: enqueue is refused because ready=0, and the dequeue proceeds.
  - Simultaneous enqueue and dequeue when neither full nor empty: occupancy is unchanged and order is preserved.
  - Pointers wrap modulo els_p; occupancy counter is clog2(els_p)+1 bits.
- Order: strict FIFO order per direction; no reordering or duplication.
- Flush: en_ls_i=0 overrides any same-cycle enqueue or dequeue. Data in flight is dropped, not delivered.

Test Plan:
- Reset then settle: hold reset_n_i=0 for 3 cycles, release with en_ls_i=1 -> all outputs 0 for 4 cycles after release; link_on_o=1 and ls_ready_o=core_ready_o=1 on cycle 5.
- FSB->node ordering: in ON, send 0x01,0x02,0x03 back-to-back on ls_v_i with core_yumi_i=0 -> ls_ready_o drops after 2 accepts; after yumi, core sees 0x01,0x02,0x03 in order; each word appears 1 cycle after its enqueue edge at the earliest.
- Node->FSB with backpressure: core sends 0x1F,0x0A with ls_yumi_i held 0 for 5 cycles -> ls_v_o=1, ls_data_o=0x1F stable; core_ready_o=0 while full; releasing yumi delivers 0x1F then 0x0A.
- Isolation mid-traffic: both FIFOs holding 1 entry, drop en_ls_i for 1 cycle -> next cycle all handshake outputs 0, flush_o=1 for exactly one cycle; after re-enable, 4 settle cycles, then core_v_o=0 and ls_v_o=0 (FIFOs empty).
- Settle glitch: en_ls_i=1 for 2 cycles, 0 for 1, then 1 -> ON reached exactly 4 cycles after the second rise; no ready asserted earlier.
- Full-rate streaming: ON, ls_v_i=1 and core_yumi_i=1 each cycle with 20 incrementing words -> all 20 delivered in order; throughput of 1 word/cycle after the first-word latency.
